// File: rtl/iogroup1_mailbox_pkg.sv
// Shared status/control layout for the iogroup1 areg4 mailbox.
// areg2 bit positions, areg3 control bits and the packed status word.
package iogroup1_mailbox_pkg;

   localparam int STAT_TX_FULL      = 16;
   localparam int STAT_TX_EMPTY     = 17;
   localparam int STAT_RX_FULL      = 18;
   localparam int STAT_RX_EMPTY     = 19;
   localparam int STAT_RX_UNDERFLOW = 20;
   localparam int STAT_TX_STALL     = 21;

   localparam int CTRL_CLR_STICKY = 0;
   localparam int CTRL_FLUSH      = 1;

   typedef struct packed {
      logic [9:0] rsvd;
      logic       tx_stall;
      logic       rx_underflow;
      logic       rx_empty;
      logic       rx_full;
      logic       tx_empty;
      logic       tx_full;
      logic [7:0] rx_count;
      logic [7:0] tx_count;
   } t_mbx_status;

endpackage

// File: rtl/iogroup1_mailbox_if.sv
// t_ios register-side bus plus the user TX/RX streams of the mailbox.
// The mailbox is the slave; the register block and user logic are the master.
interface iogroup1_mailbox_if;
   logic [31:0] areg1;
   logic [31:0] areg2;
   logic [31:0] areg3;
   logic        areg3_wr;
   logic [31:0] areg4o;
   logic        areg4_wr;
   logic        areg4_wack;
   logic        areg4_rd;
   logic        areg4_rack;
   logic [31:0] areg4i;
   logic [31:0] tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [31:0] rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;

   modport master (
      output areg1, areg3, areg3_wr, areg4o, areg4_wr, areg4_rd, tx_ready_i, rx_data_i, rx_valid_i,
      input  areg2, areg4_wack, areg4_rack, areg4i, tx_data_o, tx_valid_o, rx_ready_o
   );

   modport slave (
      input  areg1, areg3, areg3_wr, areg4o, areg4_wr, areg4_rd, tx_ready_i, rx_data_i, rx_valid_i,
      output areg2, areg4_wack, areg4_rack, areg4i, tx_data_o, tx_valid_o, rx_ready_o
   );
endinterface

// File: rtl/iogroup1_mailbox_fifo.sv
// Synchronous FIFO, head visible one cycle after push (no bypass).
// Push while full is accepted only alongside a pop; flush empties it and overrides both.
module mbx_sync_fifo #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/iogroup1_mailbox.sv
// areg4 mailbox: host writes feed a TX FIFO, host reads drain an RX FIFO; areg2 status, areg3 control.
// wack/rack one cycle after the request; a write into a full TX FIFO waits in a pending slot for space.
module iogroup1_mailbox
   import iogroup1_mailbox_pkg::*;
#(
   parameter int          DEPTH_LOG2    = 4,
   parameter logic [31:0] EMPTY_PATTERN = 32'hDEADBEEF
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   iogroup1_mailbox_if.slave  bus
);
   localparam int CW = DEPTH_LOG2 + 1;

   logic [31:0]   tx_dout, rx_dout, tx_din;
   logic [CW-1:0] tx_count, rx_count;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          flush, clr_sticky, tx_pop, tx_push, rx_pop, rx_push;
   logic          wr_direct, wr_stall, pend_push;
   logic          wack_q, wack_d, rack_q, rack_d, pend_q, pend_d;
   logic          udf_q, udf_d, stall_q, stall_d;
   logic [31:0]   rdat_q, rdat_d, pend_dat_q, pend_dat_d;
   t_mbx_status   status_q, status_d;
   logic          unused_ok;

   assign unused_ok = ^{bus.areg1, bus.areg3[31:2]};

   assign bus.areg2      = status_q;
   assign bus.areg4_wack = wack_q;
   assign bus.areg4_rack = rack_q;
   assign bus.areg4i     = rdat_q;
   assign bus.tx_data_o  = tx_dout;
   assign bus.tx_valid_o = ~tx_empty;
   assign bus.rx_ready_o = ~rx_full;

   always_comb begin
      flush      = bus.areg3_wr & bus.areg3[CTRL_FLUSH];
      clr_sticky = bus.areg3_wr & bus.areg3[CTRL_CLR_STICKY];
      tx_pop     = bus.tx_ready_i & ~tx_empty;
      // A write colliding with a flush is parked and lands in the emptied FIFO next cycle.
      wr_direct  = bus.areg4_wr & ~pend_q & ~tx_full & ~flush;
      wr_stall   = bus.areg4_wr & ~pend_q & ~wr_direct;
      pend_push  = pend_q & ~flush & (~tx_full | tx_pop);
      tx_push    = wr_direct | pend_push;
      tx_din     = pend_q ? pend_dat_q : bus.areg4o;
      rx_pop     = bus.areg4_rd & ~rx_empty;
      rx_push    = bus.rx_valid_i & ~rx_full;

      pend_d     = pend_push ? 1'b0 : (wr_stall ? 1'b1 : pend_q);
      pend_dat_d = wr_stall ? bus.areg4o : pend_dat_q;
      wack_d     = tx_push;
      rack_d     = bus.areg4_rd;
      rdat_d     = rdat_q;
      if (bus.areg4_rd) rdat_d = rx_empty ? EMPTY_PATTERN : rx_dout;

      stall_d = (stall_q & ~clr_sticky) | (wr_stall & tx_full);
      udf_d   = (udf_q & ~clr_sticky) | (bus.areg4_rd & rx_empty);

      status_d                    = '0;
      status_d.tx_count           = 8'(tx_count);
      status_d.rx_count           = 8'(rx_count);
      status_d[STAT_TX_FULL]      = tx_full;
      status_d[STAT_TX_EMPTY]     = tx_empty;
      status_d[STAT_RX_FULL]      = rx_full;
      status_d[STAT_RX_EMPTY]     = rx_empty;
      status_d[STAT_RX_UNDERFLOW] = udf_q;
      status_d[STAT_TX_STALL]     = stall_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wack_q     <= 1'b0;
         rack_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_dat_q <= '0;
         rdat_q     <= '0;
         udf_q      <= 1'b0;
         stall_q    <= 1'b0;
         status_q   <= '0;
      end else begin
         wack_q     <= wack_d;
         rack_q     <= rack_d;
         pend_q     <= pend_d;
         pend_dat_q <= pend_dat_d;
         rdat_q     <= rdat_d;
         udf_q      <= udf_d;
         stall_q    <= stall_d;
         status_q   <= status_d;
      end
   end

   mbx_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .push(tx_push), .pop(tx_pop), .flush(flush),
      .din(tx_din), .dout(tx_dout), .count(tx_count),
      .full(tx_full), .empty(tx_empty)
   );

   mbx_sync_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .push(rx_push), .pop(rx_pop), .flush(flush),
      .din(bus.rx_data_i), .dout(rx_dout), .count(rx_count),
      .full(rx_full), .empty(rx_empty)
   );

endmodule

// File: tb/tb_iogroup1_mailbox.sv
// Bench for iogroup1_mailbox: queue-level reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_iogroup1_mailbox;
   localparam int          DEPTH = 16;
   localparam logic [31:0] EMPTY = 32'hDEADBEEF;

   logic clk_i   = 1'b0;
   logic rst_n_i = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   iogroup1_mailbox_if bus();

   iogroup1_mailbox #(.DEPTH_LOG2(4), .EMPTY_PATTERN(EMPTY)) dut (
      .clk_i(clk_i),
      .rst_n_i(rst_n_i),
      .bus(bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: queues for the FIFOs, expected registered outputs.
   logic [31:0] m_tx[$];
   logic [31:0] m_rx[$];
   bit          m_pend, m_udf, m_stall, m_wack, m_rack;
   logic [31:0] m_pend_dat, m_rdat, m_areg2;

   always @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         m_tx.delete();
         m_rx.delete();
         m_pend = 0; m_udf = 0; m_stall = 0; m_wack = 0; m_rack = 0;
         m_pend_dat = '0; m_rdat = '0; m_areg2 = '0;
      end else begin
         int tn, rn;
         bit flush, clr, pop, push;
         logic [31:0] pdat;
         tn    = m_tx.size();
         rn    = m_rx.size();
         flush = bus.areg3_wr && bus.areg3[1];
         clr   = bus.areg3_wr && bus.areg3[0];
         m_areg2 = {10'd0, m_stall, m_udf, rn == 0, rn == DEPTH, tn == 0, tn == DEPTH, 8'(rn), 8'(tn)};
         if (clr) begin m_stall = 0; m_udf = 0; end
         pop  = bus.tx_ready_i && tn > 0;
         push = 0;
         pdat = bus.areg4o;
         if (bus.areg4_wr && !m_pend) begin
            if (tn < DEPTH && !flush) push = 1;
            else begin
               m_pend = 1;
               m_pend_dat = bus.areg4o;
               if (tn == DEPTH) m_stall = 1;
            end
         end else if (m_pend && !flush && (tn < DEPTH || pop)) begin
            push = 1; pdat = m_pend_dat; m_pend = 0;
         end
         m_wack = push;
         m_rack = bus.areg4_rd;
         if (bus.areg4_rd) begin
            if (rn > 0) m_rdat = m_rx[0];
            else begin m_rdat = EMPTY; m_udf = 1; end
         end
         if (flush) begin
            m_tx.delete();
            m_rx.delete();
         end else begin
            if (pop) void'(m_tx.pop_front());
            if (push) m_tx.push_back(pdat);
            if (bus.areg4_rd && rn > 0) void'(m_rx.pop_front());
            if (bus.rx_valid_i && rn < DEPTH) m_rx.push_back(bus.rx_data_i);
         end
      end
   end

   always @(posedge clk_i) begin
      #2;
      chk("m_wack", 32'(bus.areg4_wack), 32'(m_wack));
      chk("m_rack", 32'(bus.areg4_rack), 32'(m_rack));
      if (m_rack) chk("m_areg4i", bus.areg4i, m_rdat);
      chk("m_areg2", bus.areg2, m_areg2);
      chk("m_tx_valid", 32'(bus.tx_valid_o), 32'(m_tx.size() > 0));
      if (m_tx.size() > 0) chk("m_tx_data", bus.tx_data_o, m_tx[0]);
      chk("m_rx_ready", 32'(bus.rx_ready_o), 32'(m_rx.size() < DEPTH));
   end

   task automatic cyc();
      @(negedge clk_i);
   endtask

   task automatic host_write(input logic [31:0] d);
      bus.areg4o = d; bus.areg4_wr = 1'b1;
      cyc();
      bus.areg4_wr = 1'b0;
   endtask

   task automatic host_read(output logic [31:0] d);
      bus.areg4_rd = 1'b1;
      cyc();
      bus.areg4_rd = 1'b0;
      chk("read_rack", 32'(bus.areg4_rack), 32'd1);
      d = bus.areg4i;
   endtask

   task automatic ctrl(input logic [31:0] v);
      bus.areg3 = v; bus.areg3_wr = 1'b1;
      cyc();
      bus.areg3_wr = 1'b0; bus.areg3 = '0;
   endtask

   initial begin
      logic [31:0] rd;
      bus.areg1 = 32'h5555AAAA; bus.areg3 = '0; bus.areg3_wr = 0;
      bus.areg4o = '0; bus.areg4_wr = 0; bus.areg4_rd = 0;
      bus.tx_ready_i = 0; bus.rx_data_i = '0; bus.rx_valid_i = 0;

      repeat (3) cyc();
      chk("reset_areg2", bus.areg2, 32'h0);
      chk("reset_wack", 32'(bus.areg4_wack), 32'd0);
      rst_n_i = 1'b1;
      cyc();
      chk("post_reset_areg2", bus.areg2, 32'h000A0000);

      host_write(32'h11223344);
      chk("wr1_wack", 32'(bus.areg4_wack), 32'd1);
      chk("wr1_tx_valid", 32'(bus.tx_valid_o), 32'd1);
      chk("wr1_tx_data", bus.tx_data_o, 32'h11223344);
      cyc();
      chk("wr1_tx_count", 32'(bus.areg2[7:0]), 32'd1);
      chk("wr1_wack_single", 32'(bus.areg4_wack), 32'd0);
      bus.tx_ready_i = 1; cyc(); bus.tx_ready_i = 0;

      // Fill TX, then a write that has to wait for space.
      for (int i = 0; i < DEPTH; i++) host_write(32'h10000000 + 32'(i));
      host_write(32'hCAFE0017);
      chk("stall_no_wack", 32'(bus.areg4_wack), 32'd0);
      cyc();
      chk("stall_bit21", 32'(bus.areg2[21]), 32'd1);
      chk("stall_tx_count", 32'(bus.areg2[7:0]), 32'd16);
      bus.tx_ready_i = 1; cyc(); bus.tx_ready_i = 0;
      chk("stall_wack", 32'(bus.areg4_wack), 32'd1);
      chk("stall_tx_head", bus.tx_data_o, 32'h10000001);
      cyc();
      chk("stall_count_kept", 32'(bus.areg2[7:0]), 32'd16);
      bus.tx_ready_i = 1; repeat (DEPTH) cyc(); bus.tx_ready_i = 0;
      chk("drain_tx_valid", 32'(bus.tx_valid_o), 32'd0);

      bus.rx_valid_i = 1; bus.rx_data_i = 32'hA5A50001; cyc();
      bus.rx_data_i = 32'hA5A50002; cyc();
      bus.rx_valid_i = 0;
      host_read(rd); chk("rx_first", rd, 32'hA5A50001);
      host_read(rd); chk("rx_second", rd, 32'hA5A50002);
      cyc();
      chk("rx_empty_bit19", 32'(bus.areg2[19]), 32'd1);

      host_read(rd); chk("underflow_data", rd, 32'hDEADBEEF);
      cyc();
      chk("underflow_bit20", 32'(bus.areg2[20]), 32'd1);
      ctrl(32'h1);
      cyc();
      chk("clear_bit20", 32'(bus.areg2[20]), 32'd0);
      chk("clear_bit21", 32'(bus.areg2[21]), 32'd0);

      // Flush beats a simultaneous user pop.
      for (int i = 0; i < 5; i++) host_write(32'h50000000 + 32'(i));
      bus.tx_ready_i = 1; ctrl(32'h2); bus.tx_ready_i = 0;
      chk("flush_tx_valid", 32'(bus.tx_valid_o), 32'd0);
      cyc();
      chk("flush_tx_count", 32'(bus.areg2[7:0]), 32'd0);

      // RX full boundary: 17th push refused, order preserved.
      bus.rx_valid_i = 1;
      for (int i = 0; i <= DEPTH; i++) begin
         bus.rx_data_i = 32'hB0000000 + 32'(i);
         cyc();
      end
      bus.rx_valid_i = 0;
      chk("rx_full_ready", 32'(bus.rx_ready_o), 32'd0);
      cyc();
      chk("rx_full_bit18", 32'(bus.areg2[18]), 32'd1);
      chk("rx_full_count", 32'(bus.areg2[15:8]), 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         host_read(rd);
         chk("rx_order", rd, 32'hB0000000 + 32'(i));
      end

      // Pending write completes into the flushed TX FIFO.
      for (int i = 0; i < DEPTH; i++) host_write(32'h60000000 + 32'(i));
      host_write(32'hCAFE0042);
      ctrl(32'h2);
      chk("flush_pend_empty", 32'(bus.tx_valid_o), 32'd0);
      cyc();
      chk("flush_pend_wack", 32'(bus.areg4_wack), 32'd1);
      chk("flush_pend_data", bus.tx_data_o, 32'hCAFE0042);

      // Asynchronous reset while a write is pending on a full TX FIFO.
      for (int i = 1; i < DEPTH; i++) host_write(32'h70000000 + 32'(i));
      host_write(32'hCAFE0099);
      #2 rst_n_i = 1'b0;
      #1;
      chk("arst_wack", 32'(bus.areg4_wack), 32'd0);
      chk("arst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
      chk("arst_areg2", bus.areg2, 32'h0);
      repeat (2) cyc();
      rst_n_i = 1'b1;
      cyc();
      chk("arst_release_areg2", bus.areg2, 32'h000A0000);
      cyc();
      chk("arst_pend_dropped", 32'(bus.areg4_wack), 32'd0);
      chk("arst_tx_still_empty", 32'(bus.tx_valid_o), 32'd0);
      chk("arst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
      repeat (2) cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
